// File: rtl/alu_src_ctrl.sv
// Operand-source controller: accepts a 9-bit instruction, drives the ALU source
// mux for an EXEC and a WB cycle, counts completed instructions, and halts on mode 11.
module alu_src_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [1:0] alu_src,
  output logic [3:0] to_ext,
  output logic [3:0] to_inc,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic       halted,
  output logic [7:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    WB     = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [1:0] MODE_IMM  = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_REG  = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;
  localparam logic [1:0] SRC_NONE  = 2'b11;

  state_e     state_q, state_d;
  logic [8:0] instr_q, instr_d;
  logic [7:0] instr_count_q, instr_count_d;
  logic       accept;

  assign accept = instr_valid && (state_q == IDLE);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_count_d = instr_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d = instr;
          state_d = (instr[8:7] == MODE_HALT) ? HALTED : EXEC;
        end
      end
      EXEC:    state_d = WB;
      WB: begin
        instr_count_d = instr_count_q + 8'd1;
        state_d       = IDLE;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Outputs decode only from registered state and the latched instruction.
  always_comb begin
    alu_src = SRC_NONE;
    to_ext  = '0;
    to_inc  = '0;
    alu_op  = '0;
    if (state_q == EXEC || state_q == WB) begin
      alu_op = instr_q[6:4];
      case (instr_q[8:7])
        MODE_IMM: begin
          alu_src = MODE_IMM;
          to_ext  = instr_q[3:0];
        end
        MODE_INC: begin
          alu_src = MODE_INC;
          to_inc  = instr_q[3:0];
        end
        MODE_REG: alu_src = MODE_REG;
        default:  alu_src = SRC_NONE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign reg_we      = (state_q == WB);
  assign halted      = (state_q == HALTED);
  assign instr_count = instr_count_q;

endmodule

// File: doc/alu_src_ctrl.md
ALU_SRC_CTRL -- requirements
Module: alu_src_ctrl

Interface
REQ-001 The block SHALL expose port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose port reset, input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL expose port instr, input, 9 bits, the instruction word from fetch.
REQ-004 The block SHALL expose port instr_valid, input, 1 bit, high when instr is presented.
REQ-005 The block SHALL expose port instr_ready, output, 1 bit, high when the block can accept an instruction.
REQ-006 The block SHALL expose port alu_src, output, 2 bits, operand-source select to the ALU source mux.
REQ-007 The block SHALL expose port to_ext, output, 4 bits, immediate nibble for zero-extension.
REQ-008 The block SHALL expose port to_inc, output, 4 bits, nibble for the increment path.
REQ-009 The block SHALL expose port alu_op, output, 3 bits, ALU operation code.
REQ-010 The block SHALL expose port reg_we, output, 1 bit, register-file write enable.
REQ-011 The block SHALL expose port halted, output, 1 bit, high once a halt instruction has executed.
REQ-012 The block SHALL expose port instr_count, output, 8 bits, count of completed non-halt instructions.

Function
REQ-013 The instruction fields SHALL be: mode = instr[8:7], op = instr[6:4], nib = instr[3:0].
REQ-014 The mode encoding SHALL be 00 IMM, 01 INC, 10 REG, 11 HALT.
REQ-015 The FSM SHALL have exactly the states IDLE, EXEC, WB and HALTED.
REQ-016 instr_ready SHALL be 1 only in IDLE.
REQ-017 An accept SHALL occur when instr_valid and instr_ready are both 1 on a clk edge; instr SHALL then be latched into an internal 9-bit register.
REQ-018 In IDLE, an accept with mode != 11 SHALL move the FSM to EXEC.
REQ-019 In IDLE, an accept with mode = 11 SHALL move the FSM to HALTED.
REQ-020 In IDLE with no accept, the FSM SHALL stay in IDLE.
REQ-021 In EXEC, outputs SHALL be driven from the latched instruction for exactly one cycle, then the FSM SHALL move to WB.
REQ-022 In EXEC with IMM: alu_src=00, to_ext=nib, to_inc=0.
REQ-023 In EXEC with INC: alu_src=01, to_inc=nib, to_ext=0.
REQ-024 In EXEC with REG: alu_src=10, to_ext=0, to_inc=0.
REQ-025 In EXEC, alu_op SHALL equal the latched op.
REQ-026 In WB, reg_we SHALL be 1 for exactly one cycle, and alu_src, alu_op, to_ext and to_inc SHALL hold their EXEC values.
REQ-027 On leaving WB, instr_count SHALL increment by 1 modulo 256 (255 wraps to 0) and the FSM SHALL return to IDLE.
REQ-028 In IDLE and HALTED: alu_src=11 (no source), to_ext=0, to_inc=0, alu_op=0, reg_we=0.
REQ-029 HALTED SHALL be absorbing: halted=1, instr_ready=0, instr_valid ignored, and exited only by reset.
REQ-030 Latency from accept to the reg_we pulse SHALL be 2 cycles; back-to-back throughput SHALL be one instruction per 3 cycles.
REQ-031 instr_valid toggling while not in IDLE SHALL have no effect, and instr changes outside an accept edge SHALL not alter the latched instruction.
REQ-032 All outputs SHALL be registered or decoded from registered state only, with no combinational path from instr or instr_valid to any output except none.

Reset
REQ-033 reset=1 on a clk edge SHALL force IDLE, clear the latched instruction, clear instr_count to 0 and clear halted to 0, taking priority over any simultaneous accept.
REQ-034 After reset, outputs SHALL be: instr_ready=1, alu_src=11, to_ext=0, to_inc=0, alu_op=0, reg_we=0, halted=0, instr_count=0.
REQ-035 Reset asserted in EXEC or WB SHALL abort the instruction: no reg_we pulse follows and instr_count is not incremented.

Verification
REQ-036 IMM accept of instr=9'b00_101_0110 -> next cycle alu_src=00, to_ext=6, alu_op=5; the cycle after, reg_we=1; then instr_count=1 and instr_ready=1.
REQ-037 INC instr=9'b01_010_1111 followed by REG instr=9'b10_001_0000, valid held high -> alu_src sequence 01,01,11,10,10 and two reg_we pulses spaced 3 cycles apart.
REQ-038 HALT instr=9'b11_000_0000 -> halted=1 the next cycle; further valid instructions are not accepted; reset -> halted=0, instr_ready=1.
REQ-039 256 completed IMM instructions -> instr_count returns to 0.
REQ-040 Reset asserted during EXEC of an IMM instruction -> no reg_we pulse, instr_count=0, and the FSM is in IDLE on the next cycle.
REQ-041 reset and instr_valid both high in IDLE -> no accept occurs and the FSM stays in IDLE.
